window_max_collector: RTL

Downstream companion of the float running-max accumulator. It tracks the same stride/delay schedule as the accumulator and samples the accumulator output on the cycle each window completes. Completed per-window maxima go into a small FIFO and are handed to the memory-writer stage over a valid/ready handshake. Values are treated as opaque DATA_W-bit words; no float arithmetic is done here.

---
 rtl/window_max_collector.sv | 96 +++++++++
 1 files changed

// File: rtl/window_max_collector.sv
// rtl/window_max_collector.sv - per-window max capture FIFO
// Follows the accumulator's stride/delay schedule and queues each completed window maximum.
module window_max_collector #(
  parameter int DATA_W  = 32,
  parameter int DELAY_W = 7,
  parameter int DEPTH   = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         run,
  input  logic                         running,
  input  logic [DELAY_W-1:0]           strideMinusOne,
  input  logic [DELAY_W-1:0]           delay0,
  input  logic [DATA_W-1:0]            in0,
  output logic [DATA_W-1:0]            out_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         overflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0]   CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0]   CNT_FULL  = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0]   PTR_ONE   = PTR_W'(1);
  localparam logic [DELAY_W-1:0] DELAY_ONE = DELAY_W'(1);

  logic [DATA_W-1:0]  mem [DEPTH];
  logic [DELAY_W-1:0] delay;
  logic               primed;
  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W-1:0]   wr_ptr;

  logic zero;
  logic capture;
  logic full;
  logic pop;
  logic push;
  logic drop;

  // The first zero after run only primes: the value at that point predates any window.
  assign zero    = (delay == '0);
  assign capture = running && !run && zero && primed;
  assign full    = (count == CNT_FULL);
  assign pop     = out_valid && out_ready && !run;
  assign push    = capture && (!full || pop);
  assign drop    = capture && full && !pop;

  assign out_valid = (count != '0);
  assign out_data  = out_valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= in0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      delay    <= '0;
      primed   <= 1'b0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else if (run) begin
      delay    <= delay0;
      primed   <= 1'b0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      delay <= zero ? strideMinusOne : (delay - DELAY_ONE);
      if (running && zero) begin
        primed <= 1'b1;
      end
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      if (push && !pop) begin
        count <= count + CNT_ONE;
      end else if (pop && !push) begin
        count <= count - CNT_ONE;
      end
      if (drop) begin
        overflow <= 1'b1;
      end
    end
  end

endmodule
